uncached_store_buffer: RTL and testbench

Posted-write buffer for the uncached data path, between the core-side uncached `dbus` request (after address translation) and the `DBusToCBus`-equivalent port on the `CBusArbiter`. Uncached stores (MMIO, uart, etc.) complete to the core at once and drain to the cache bus in order. Uncached loads go to the bus as single reads, but only after every earlier buffered store has drained, which preserves program order.

---
 rtl/uncached_store_buffer.sv | 207 ++++++++++++++++++++
 tb/tb_uncached_store_buffer.sv | 300 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uncached_store_buffer.sv
// Posted-write buffer between the uncached dbus port and the cache bus arbiter.
// Define UNCACHED_STORE_BUFFER_EN to buffer stores; otherwise every access blocks until its bus beat.
module uncached_store_buffer #(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        dreq_valid,
  input  logic [31:0] dreq_addr,
  input  logic [2:0]  dreq_size,
  input  logic [3:0]  dreq_strobe,
  input  logic [31:0] dreq_data,
  output logic        dresp_addr_ok,
  output logic        dresp_data_ok,
  output logic [31:0] dresp_data,
  output logic        creq_valid,
  output logic        creq_is_write,
  output logic [2:0]  creq_size,
  output logic [31:0] creq_addr,
  output logic [3:0]  creq_strobe,
  output logic [31:0] creq_data,
  output logic [3:0]  creq_len,
  input  logic        cresp_ready,
  input  logic        cresp_last,
  input  logic [31:0] cresp_data
);

  localparam logic [3:0] MLEN1 = 4'd0;

  typedef enum logic [1:0] {StIdle, StWrite, StRead} state_e;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
    $error("uncached_store_buffer: DEPTH must be a power of two >= 2");
  end

  state_e state_q;
  logic   beat_done;

  assign beat_done = cresp_ready & cresp_last;

`ifdef UNCACHED_STORE_BUFFER_EN
  localparam int unsigned PtrW   = $clog2(DEPTH);
  localparam logic [PtrW:0] DepthC = (PtrW + 1)'(DEPTH);

  logic [31:0]     fifo_addr [DEPTH];
  logic [2:0]      fifo_size [DEPTH];
  logic [3:0]      fifo_strb [DEPTH];
  logic [31:0]     fifo_data [DEPTH];
  logic [PtrW-1:0] wptr_q, rptr_q;
  logic [PtrW:0]   count_q;
  logic [31:0]     ld_addr_q;
  logic [2:0]      ld_size_q;
  logic            is_store, is_load, push, pop;

  assign is_store = dreq_valid & (|dreq_strobe);
  assign is_load  = dreq_valid & ~(|dreq_strobe);
  assign push     = is_store & (count_q < DepthC);
  assign pop      = (state_q == StWrite) & beat_done;

  always_ff @(posedge clk) begin
    if (push) begin
      fifo_addr[wptr_q] <= dreq_addr;
      fifo_size[wptr_q] <= dreq_size;
      fifo_strb[wptr_q] <= dreq_strobe;
      fifo_data[wptr_q] <= dreq_data;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      if (push) wptr_q <= wptr_q + 1'b1;
      if (pop)  rptr_q <= rptr_q + 1'b1;
      if (push && !pop)      count_q <= count_q + 1'b1;
      else if (pop && !push) count_q <= count_q - 1'b1;
    end
  end

  // Buffered stores always drain before a load may start, keeping program order.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= StIdle;
      ld_addr_q <= '0;
      ld_size_q <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (count_q != '0) begin
            state_q <= StWrite;
          end else if (is_load) begin
            state_q   <= StRead;
            ld_addr_q <= dreq_addr;
            ld_size_q <= dreq_size;
          end
        end
        StWrite: if (beat_done) state_q <= StIdle;
        StRead:  if (beat_done) state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    creq_valid    = 1'b0;
    creq_is_write = 1'b0;
    creq_size     = '0;
    creq_addr     = '0;
    creq_strobe   = '0;
    creq_data     = '0;
    creq_len      = '0;
    dresp_addr_ok = 1'b0;
    dresp_data_ok = 1'b0;
    dresp_data    = '0;
    case (state_q)
      StWrite: begin
        creq_valid    = 1'b1;
        creq_is_write = 1'b1;
        creq_size     = fifo_size[rptr_q];
        creq_addr     = fifo_addr[rptr_q];
        creq_strobe   = fifo_strb[rptr_q];
        creq_data     = fifo_data[rptr_q];
        creq_len      = MLEN1;
      end
      StRead: begin
        creq_valid = 1'b1;
        creq_size  = ld_size_q;
        creq_addr  = ld_addr_q;
        creq_len   = MLEN1;
        if (beat_done) begin
          dresp_addr_ok = 1'b1;
          dresp_data_ok = 1'b1;
          dresp_data    = cresp_data;
        end
      end
      default: ;
    endcase
    // Posted store completes to the core as soon as it has a slot.
    if (push) begin
      dresp_addr_ok = 1'b1;
      dresp_data_ok = 1'b1;
    end
  end

`else
  logic        req_write_q;
  logic [31:0] req_addr_q, req_data_q;
  logic [2:0]  req_size_q;
  logic [3:0]  req_strb_q;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q     <= StIdle;
      req_write_q <= 1'b0;
      req_addr_q  <= '0;
      req_data_q  <= '0;
      req_size_q  <= '0;
      req_strb_q  <= '0;
    end else begin
      case (state_q)
        StIdle: begin
          if (dreq_valid) begin
            state_q     <= StRead;
            req_write_q <= |dreq_strobe;
            req_addr_q  <= dreq_addr;
            req_data_q  <= dreq_data;
            req_size_q  <= dreq_size;
            req_strb_q  <= dreq_strobe;
          end
        end
        StRead:  if (beat_done) state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

  always_comb begin
    creq_valid    = 1'b0;
    creq_is_write = 1'b0;
    creq_size     = '0;
    creq_addr     = '0;
    creq_strobe   = '0;
    creq_data     = '0;
    creq_len      = '0;
    dresp_addr_ok = 1'b0;
    dresp_data_ok = 1'b0;
    dresp_data    = '0;
    if (state_q == StRead) begin
      creq_valid    = 1'b1;
      creq_is_write = req_write_q;
      creq_size     = req_size_q;
      creq_addr     = req_addr_q;
      creq_strobe   = req_strb_q;
      creq_data     = req_write_q ? req_data_q : '0;
      creq_len      = MLEN1;
      if (beat_done) begin
        dresp_addr_ok = 1'b1;
        dresp_data_ok = 1'b1;
        dresp_data    = req_write_q ? '0 : cresp_data;
      end
    end
  end
`endif

endmodule

// File: tb/tb_uncached_store_buffer.sv
// Scoreboard bench for uncached_store_buffer: in-order bus transaction queue plus core handshake model.
module tb_uncached_store_buffer;
  localparam int unsigned DEPTH = 4;
`ifdef UNCACHED_STORE_BUFFER_EN
  localparam bit Buffered = 1'b1;
`else
  localparam bit Buffered = 1'b0;
`endif

  typedef struct packed {
    logic        is_write;
    logic [31:0] addr;
    logic [2:0]  size;
    logic [3:0]  strobe;
    logic [31:0] data;
  } txn_t;

  logic        clk = 1'b0;
  logic        resetn;
  logic        dreq_valid;
  logic [31:0] dreq_addr;
  logic [2:0]  dreq_size;
  logic [3:0]  dreq_strobe;
  logic [31:0] dreq_data;
  logic        dresp_addr_ok, dresp_data_ok;
  logic [31:0] dresp_data;
  logic        creq_valid, creq_is_write;
  logic [2:0]  creq_size;
  logic [31:0] creq_addr;
  logic [3:0]  creq_strobe;
  logic [31:0] creq_data;
  logic [3:0]  creq_len;
  logic        cresp_ready, cresp_last;
  logic [31:0] cresp_data;

  uncached_store_buffer #(.DEPTH(DEPTH)) dut (
    .clk(clk), .resetn(resetn),
    .dreq_valid(dreq_valid), .dreq_addr(dreq_addr), .dreq_size(dreq_size),
    .dreq_strobe(dreq_strobe), .dreq_data(dreq_data),
    .dresp_addr_ok(dresp_addr_ok), .dresp_data_ok(dresp_data_ok), .dresp_data(dresp_data),
    .creq_valid(creq_valid), .creq_is_write(creq_is_write), .creq_size(creq_size),
    .creq_addr(creq_addr), .creq_strobe(creq_strobe), .creq_data(creq_data),
    .creq_len(creq_len),
    .cresp_ready(cresp_ready), .cresp_last(cresp_last), .cresp_data(cresp_data)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  txn_t stim_q[$];
  txn_t bus_q[$];
  txn_t req_cur;
  bit   req_active = 1'b0, req_acked = 1'b0;
  bit   rand_gaps = 1'b0, bus_hold = 1'b0, force_rd = 1'b0;
  logic [31:0] force_val = '0, last_load_data = '0;
  int unsigned bus_wait = 0, wait_max = 3;
  int unsigned buffered = 0;

  // Previous-cycle view used to predict creq_valid.
  bit prev_valid = 0, prev_done = 0, prev_act_valid = 0;
  bit prev_load_pend = 0, prev_pend = 0, prev_pend_write = 0;
  int unsigned prev_buf = 0;
  logic [75:0] prev_fields = '0;

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic txn_t mk(input bit w, input logic [31:0] a, input logic [3:0] s,
                              input logic [31:0] d);
    txn_t t;
    t.is_write = w;
    t.addr     = a;
    t.size     = 3'd2;
    t.strobe   = w ? s : 4'h0;
    t.data     = d;
    return t;
  endfunction

  // Core driver: one request at a time, held until acknowledged.
  always @(posedge clk) begin
    #1;
    if (!resetn) begin
      req_active = 0;
      req_acked  = 0;
      dreq_valid = 0; dreq_addr = '0; dreq_size = '0; dreq_strobe = '0; dreq_data = '0;
    end else begin
      if (req_active && req_acked) begin
        req_active = 0;
        req_acked  = 0;
        dreq_valid = 0; dreq_addr = '0; dreq_size = '0; dreq_strobe = '0; dreq_data = '0;
      end
      if (!req_active && stim_q.size() != 0 && (!rand_gaps || $urandom_range(0, 3) != 0)) begin
        txn_t e;
        req_cur    = stim_q.pop_front();
        req_active = 1;
        e = req_cur;
        if (!e.is_write) e.data = '0;
        bus_q.push_back(e);
        dreq_valid  = 1;
        dreq_addr   = req_cur.addr;
        dreq_size   = req_cur.size;
        dreq_strobe = req_cur.strobe;
        dreq_data   = req_cur.data;
      end
    end
  end

  // Bus responder: single-beat replies after a random wait.
  always @(posedge clk) begin
    #1;
    cresp_ready = 0; cresp_last = 0; cresp_data = '0;
    if (resetn && creq_valid && !bus_hold) begin
      if (bus_wait == 0) begin
        cresp_ready = 1;
        cresp_last  = 1;
        cresp_data  = (force_rd && !creq_is_write) ? force_val : $urandom();
        bus_wait    = $urandom_range(0, wait_max);
      end else begin
        bus_wait--;
      end
    end
  end

  // Monitor: pops expected bus transactions and checks the core handshake.
  always @(negedge clk) begin : mon
    txn_t        e;
    bit          done, done_read, done_write, exp_valid, exp_ok;
    int unsigned buf_now;
    logic [75:0] fields;
    if (!resetn) begin
      prev_valid = 0; prev_done = 0; prev_act_valid = 0; prev_buf = 0;
      prev_load_pend = 0; prev_pend = 0; prev_pend_write = 0;
      buffered = 0;
      req_acked = 0;
    end else begin
      fields  = {creq_is_write, creq_size, creq_addr, creq_strobe, creq_data, creq_len};
      done    = creq_valid & cresp_ready & cresp_last;
      buf_now = buffered;
      if (prev_done)       exp_valid = 0;
      else if (prev_valid) exp_valid = 1;
      else if (Buffered)   exp_valid = (prev_buf != 0) || prev_load_pend;
      else                 exp_valid = prev_pend;
      check("creq_valid", 80'(creq_valid), 80'(exp_valid));
      if (exp_valid && !prev_valid)
        check("creq_is_write_start", 80'(creq_is_write),
              80'(Buffered ? (prev_buf != 0) : prev_pend_write));
      if (prev_act_valid && !prev_done && creq_valid)
        check("creq_stable", 80'(fields), 80'(prev_fields));
      if (!creq_valid) check("creq_idle_zero", 80'(fields), 80'(0));

      done_read  = 0;
      done_write = 0;
      if (done) begin
        if (bus_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_bus_txn: got transfer at addr %h, required none", creq_addr);
        end else begin
          e = bus_q.pop_front();
          check("bus_is_write", 80'(creq_is_write), 80'(e.is_write));
          check("bus_addr", 80'(creq_addr), 80'(e.addr));
          check("bus_size", 80'(creq_size), 80'(e.size));
          check("bus_len", 80'(creq_len), 80'(0));
          check("bus_strobe", 80'(creq_strobe), 80'(e.strobe));
          if (e.is_write) check("bus_data", 80'(creq_data), 80'(e.data));
          done_read  = !e.is_write;
          done_write = e.is_write;
        end
      end

      exp_ok = 0;
      if (req_active) begin
        if (Buffered && req_cur.is_write) exp_ok = (buf_now < DEPTH);
        else if (Buffered)                exp_ok = done_read;
        else                              exp_ok = done;
      end
      check("dresp_data_ok", 80'(dresp_data_ok), 80'(exp_ok));
      check("dresp_addr_ok", 80'(dresp_addr_ok), 80'(exp_ok));
      if (exp_ok && !req_cur.is_write) begin
        check("load_data", 80'(dresp_data), 80'(cresp_data));
        last_load_data = dresp_data;
      end
      if (exp_ok) req_acked = 1;
      if (Buffered && exp_ok && req_cur.is_write) buffered++;
      if (Buffered && done_write && buffered != 0) buffered--;

      prev_done       = done;
      prev_valid      = exp_valid;
      prev_act_valid  = creq_valid;
      prev_fields     = fields;
      prev_buf        = buf_now;
      prev_load_pend  = req_active && !req_cur.is_write && !exp_ok;
      prev_pend       = req_active && !exp_ok;
      prev_pend_write = req_cur.is_write;
    end
  end

  task automatic wait_idle(input int unsigned budget, input string name);
    int unsigned n = 0;
    while ((stim_q.size() != 0 || req_active || bus_q.size() != 0 || buffered != 0) &&
           n < budget) begin
      @(negedge clk);
      n++;
    end
    checks++;
    if (n >= budget) begin
      errors++;
      $display("FAIL %s: drain timeout, got %0d bus txns outstanding, required 0", name,
               bus_q.size());
    end
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog");
  end

  initial begin
    dreq_valid = 0; dreq_addr = '0; dreq_size = '0; dreq_strobe = '0; dreq_data = '0;
    cresp_ready = 0; cresp_last = 0; cresp_data = '0;
    resetn = 1;
    #2 resetn = 0;
    repeat (3) @(posedge clk);
    #3 resetn = 1;
    @(negedge clk);
    check("reset_creq_valid", 80'(creq_valid), 80'(0));
    check("reset_dresp", 80'({dresp_addr_ok, dresp_data_ok, dresp_data}), 80'(0));

    // Single store.
    stim_q.push_back(mk(1, 32'hBFAF_8000, 4'hF, 32'h1234_5678));
    wait_idle(100, "single_store");

    // Five stores against a stalled bus.
    bus_hold = 1;
    for (int i = 0; i < 5; i++)
      stim_q.push_back(mk(1, 32'hBFD0_0000 + 32'(i * 4), 4'hF, 32'hA5A5_0000 + 32'(i)));
    repeat (12) @(negedge clk);
    check("stalled_store_addr_ok", 80'(dresp_addr_ok), 80'(0));
    check("stalled_bus_valid", 80'(creq_valid), 80'(1));
    bus_hold = 0;
    wait_idle(200, "five_stores");

    // Stores A, B then load C.
    force_rd  = 1;
    force_val = 32'hDEAD_BEEF;
    stim_q.push_back(mk(1, 32'hBFE0_0000, 4'h3, 32'h0000_AAAA));
    stim_q.push_back(mk(1, 32'hBFE0_0004, 4'hC, 32'hBBBB_0000));
    stim_q.push_back(mk(0, 32'hBFE0_0008, 4'h0, 32'h0));
    wait_idle(200, "stores_then_load");
    check("load_c_data", 80'(last_load_data), 80'(32'hDEAD_BEEF));
    force_rd = 0;

    // Load with nothing buffered.
    stim_q.push_back(mk(0, 32'hBFF0_0010, 4'h0, 32'h0));
    wait_idle(100, "empty_load");

    // Asynchronous reset in the middle of a write.
    bus_hold = 1;
    for (int i = 0; i < 3; i++)
      stim_q.push_back(mk(1, 32'hBF00_0100 + 32'(i * 4), 4'hF, 32'h5555_0000 + 32'(i)));
    repeat (10) @(negedge clk);
    check("valid_before_reset", 80'(creq_valid), 80'(1));
    @(posedge clk);
    #3 resetn = 0;
    stim_q.delete();
    bus_q.delete();
    #1 check("valid_drops_async", 80'(creq_valid), 80'(0));
    bus_hold = 0;
    repeat (2) @(posedge clk);
    #3 resetn = 1;
    repeat (20) @(negedge clk);
    check("no_writes_after_reset", 80'(creq_valid), 80'(0));

    // Randomised traffic.
    rand_gaps = 1;
    wait_max  = 6;
    for (int i = 0; i < 300; i++) begin
      txn_t t;
      t.is_write = ($urandom_range(0, 9) < 6);
      t.addr     = $urandom() & 32'hFFFF_FFFC;
      t.size     = 3'($urandom_range(0, 2));
      t.strobe   = t.is_write ? 4'($urandom_range(1, 15)) : 4'h0;
      t.data     = $urandom();
      stim_q.push_back(t);
    end
    wait_idle(20000, "random_traffic");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
